gpu_cmd_issuer: RTL and testbench
=================================

# gpu_cmd_issuer

CPU-side initiator for the GPU command handshake. Accepts display opcodes from the CPU execute stage and buffers them in a small FIFO. Presents each one to the GPU over `gpu_cmd` / `gpu_cmd_submitted` / `gpu_ready`, one command in flight at a time. Rejects opcodes that are not GPU work and reports an idle flag the CPU uses to stall on display completion.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CMD_W`, 16: command width; fixed at 16 for CHIP-8 opcodes.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_in`  in  16  opcode from CPU.
- `cmd_valid`  in  1  `cmd_in` is valid this cycle.
- `cmd_accept`  out  1  handshake consumed this cycle when `cmd_valid & cmd_accept`; equals `!full`.
- `cmd_reject`  out  1  registered one-cycle pulse: the consumed opcode was not a GPU command and was dropped.
- `gpu_cmd`  out  16  registered command to GPU; holds its value until the next submit.
- `gpu_cmd_submitted`  out  1  registered one-cycle submit pulse.
- `gpu_ready`  in  1  GPU is waiting for a command.
- `gpu_idle`  out  1  `state==IDLE & fifo empty & gpu_ready`.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Legal GPU opcodes:
  - `16'h00E0` (CLS).
  - `cmd_in[15:12]==4'hD` (DRW Vx,Vy,n).
- Legal consumed opcode → pushed into the FIFO.
- Illegal consumed opcode → not pushed; `cmd_reject`=1 next cycle.
- FSM states: IDLE, SUBMIT, WAIT_BUSY, WAIT_READY.
  - IDLE: if FIFO non-empty and `gpu_ready`, pop the head into `gpu_cmd`, set `gpu_cmd_submitted`, go to SUBMIT. Otherwise stay.
  - SUBMIT: lasts one cycle; clear `gpu_cmd_submitted`; go to WAIT_BUSY.
  - WAIT_BUSY: `gpu_ready`=0 → WAIT_READY. Otherwise stay. This tolerates a GPU slower than one cycle to leave its wait state.
  - WAIT_READY: `gpu_ready`=1 → IDLE.
- Never more than one outstanding command.
- No submit while `gpu_ready`=0.
- Push and pop may occur in the same cycle; `fifo_level` is unchanged in that case.
- Full: `cmd_accept`=0, even if a pop occurs in the same cycle. There is no bypass and no overwrite.
- Empty: the FSM holds IDLE. `gpu_cmd` keeps the last submitted value.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty are derived from `fifo_level`.

## Timing
- Reset values (immediate on `rst`, asynchronous):
  - state IDLE; FIFO pointers and `fifo_level` 0.
  - `gpu_cmd`=16'h0000; `gpu_cmd_submitted`=0; `cmd_reject`=0.
  - `cmd_accept`=1.
  - `gpu_idle` follows `gpu_ready` combinationally.
- Latency: push at edge N, with FSM in IDLE and `gpu_ready`=1:
  - pop and submit set at edge N+1;
  - `gpu_cmd_submitted` high during cycle N+1 to N+2;
  - the GPU samples it at edge N+2.
- Minimum spacing between submits, with a GPU that finishes instantly: 4 cycles (SUBMIT, WAIT_BUSY, WAIT_READY, IDLE).
- `cmd_reject` asserts the cycle after consumption, for exactly one cycle.
- Reset mid-operation:
  - the submit pulse is truncated and queued commands are discarded;
  - after reset deasserts, the FSM resumes in IDLE and re-syncs on `gpu_ready`.
- `gpu_ready` dropping while the FSM is in IDLE with no submit has no effect; the FSM waits.

## Structure
- Shared package `chip8_gpu_pkg`:
  - FSM state encodings;
  - `OP_CLS`=16'h00E0 and `OP_DRW_HI`=4'hD;
  - the `is_gpu_op()` function, shared with the GPU decoder.
- Sub-module `sync_fifo` (DEPTH, WIDTH; push/pop/full/empty/level; async active-high reset). Reusable elsewhere, e.g. for the keypad queue.
- Top level: FSM, opcode filter and output registers. The FIFO is instantiated once.

## Test plan
- Reset with `gpu_ready`=1:
  - `gpu_idle`=1, `cmd_accept`=1, `gpu_cmd`=0, `fifo_level`=0;
  - push 16'h00E0 → `gpu_cmd`=16'h00E0 with a single-cycle submit, 1 cycle after the push edge.
- Push 16'h6A05 → `cmd_reject` pulses 1 cycle, `fifo_level` stays 0, no submit.
- GPU model holds `gpu_ready`=0 for 10 cycles per command; push D125, D236, D347, D458, D569 back-to-back:
  - first four accepted, fifth stalls with `cmd_accept`=0;
  - all five are submitted in order, each exactly once;
  - no submit while ready is low.
- GPU model lags 3 cycles before dropping `gpu_ready` → FSM holds WAIT_BUSY and there is no duplicate submit.
- Simultaneous push and pop at `fifo_level`=2 → level stays 2 and data order is preserved.
- Assert `rst` during SUBMIT with 3 entries queued:
  - submit clears immediately and `fifo_level`=0;
  - after release, a new push submits normally.

Source files
------------

// File: rtl/chip8_gpu_pkg.sv
// Shared CHIP-8 GPU definitions: issuer FSM encoding and the opcode filter
// used by both the CPU-side issuer and the GPU decoder.
package chip8_gpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SUBMIT     = 2'd1,
    ST_WAIT_BUSY  = 2'd2,
    ST_WAIT_READY = 2'd3
  } gpu_state_e;

  localparam logic [15:0] OP_CLS    = 16'h00E0;
  localparam logic [3:0]  OP_DRW_HI = 4'hD;

  function automatic logic is_gpu_op(input logic [15:0] op);
    return (op == OP_CLS) || (op[15:12] == OP_DRW_HI);
  endfunction

endpackage

// File: rtl/gpu_cmd_issuer_if.sv
// CPU-execute and GPU handshake signals of the command issuer, bundled so the
// issuer and its environment connect through a single port.
interface gpu_cmd_issuer_if #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 16
);
  logic [CMD_W-1:0]        cmd_in;
  logic                    cmd_valid;
  logic                    cmd_accept;
  logic                    cmd_reject;
  logic [CMD_W-1:0]        gpu_cmd;
  logic                    gpu_cmd_submitted;
  logic                    gpu_ready;
  logic                    gpu_idle;
  logic [$clog2(DEPTH):0]  fifo_level;

  // Issuer side: it initiates GPU transactions.
  modport master (
    input  cmd_in, cmd_valid, gpu_ready,
    output cmd_accept, cmd_reject, gpu_cmd, gpu_cmd_submitted, gpu_idle, fifo_level
  );

  // Environment side: CPU execute stage plus the GPU.
  modport slave (
    output cmd_in, cmd_valid, gpu_ready,
    input  cmd_accept, cmd_reject, gpu_cmd, gpu_cmd_submitted, gpu_idle, fifo_level
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty derive from the count so
// the pointers can wrap naturally at a power-of-two depth.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage needs no reset: nothing is read until the level says it was written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_issuer.sv
// CPU-side GPU command issuer: filters display opcodes into a FIFO and hands
// them to the GPU one at a time over a submit/ready handshake.
module gpu_cmd_issuer
  import chip8_gpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CMD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  gpu_cmd_issuer_if.master bus
);
  localparam int LW = $clog2(DEPTH) + 1;

  gpu_state_e       r_state;
  gpu_state_e       w_next;
  logic             w_full;
  logic             w_empty;
  logic             w_legal;
  logic             w_consume;
  logic             w_push;
  logic             w_pop;
  logic [CMD_W-1:0] w_head;
  logic [LW-1:0]    w_level;
  logic [CMD_W-1:0] r_gpu_cmd;
  logic             r_submitted;
  logic             r_reject;

  assign w_consume = bus.cmd_valid & ~w_full;
  assign w_legal   = is_gpu_op(bus.cmd_in);
  assign w_push    = w_consume & w_legal;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // WAIT_BUSY waits for ready to fall so a slow GPU never sees a second submit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (!w_empty && bus.gpu_ready) w_next = ST_SUBMIT;
      ST_SUBMIT:     w_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY:  if (!bus.gpu_ready) w_next = ST_WAIT_READY;
      ST_WAIT_READY: if (bus.gpu_ready) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop = 1'b0;
    if (r_state == ST_IDLE && !w_empty && bus.gpu_ready) w_pop = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gpu_cmd   <= '0;
      r_submitted <= 1'b0;
      r_reject    <= 1'b0;
    end else begin
      r_submitted <= w_pop;
      r_reject    <= w_consume & ~w_legal;
      if (w_pop) r_gpu_cmd <= w_head;
    end
  end

  assign bus.cmd_accept        = ~w_full;
  assign bus.cmd_reject        = r_reject;
  assign bus.gpu_cmd           = r_gpu_cmd;
  assign bus.gpu_cmd_submitted = r_submitted;
  assign bus.gpu_idle          = (r_state == ST_IDLE) & w_empty & bus.gpu_ready;
  assign bus.fifo_level        = w_level;

endmodule

// File: tb/tb_gpu_cmd_issuer.sv
// Directed bench for gpu_cmd_issuer with a small GPU ready model (lag/busy).
module tb_gpu_cmd_issuer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpu_cmd_issuer_if #(.DEPTH(4), .CMD_W(16)) bus ();
  gpu_cmd_issuer #(.DEPTH(4), .CMD_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base;

  logic man_ready = 1'b1;
  logic model_en  = 1'b0;
  logic m_ready;
  logic ready_at_edge;
  int   lag_len  = 0;
  int   busy_len = 1;
  int   lag_cnt;
  int   busy_cnt;

  logic [15:0] sub_q [$];
  int          sub_cyc [$];

  logic [15:0] vec3 [5] = '{16'hD125, 16'hD236, 16'hD347, 16'hD458, 16'hD569};

  assign bus.gpu_ready = model_en ? m_ready : man_ready;

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    ready_at_edge <= bus.gpu_ready;
  end

  // GPU model: after seeing a submit, waits lag_len cycles, then drops ready for busy_len cycles.
  always @(posedge clk or posedge rst) begin
    if (rst || !model_en) begin
      m_ready  <= 1'b1;
      lag_cnt  <= 0;
      busy_cnt <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) m_ready <= 1'b1;
    end else if (lag_cnt != 0) begin
      lag_cnt <= lag_cnt - 1;
      if (lag_cnt == 1) begin
        m_ready  <= 1'b0;
        busy_cnt <= busy_len;
      end
    end else if (bus.gpu_cmd_submitted) begin
      if (lag_len == 0) begin
        m_ready  <= 1'b0;
        busy_cnt <= busy_len;
      end else begin
        lag_cnt <= lag_len;
      end
    end
  end

  // Submit monitor: logs every pulse and checks ready was high at the pop edge.
  always @(posedge clk) begin
    #1;
    if (bus.gpu_cmd_submitted === 1'b1) begin
      sub_q.push_back(bus.gpu_cmd);
      sub_cyc.push_back(cyc);
      n_tests++;
      assert (ready_at_edge === 1'b1) else begin
        n_fail++;
        $error("FAIL submit_ready: observed ready %b at pop edge, expected 1", ready_at_edge);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_subs(input int n, input string tag);
    int g = 0;
    while (sub_q.size() < n && g < 300) begin
      tick();
      g++;
    end
    check(tag, 32'(sub_q.size() >= n), 1);
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (bus.gpu_idle !== 1'b1 && g < 300) begin
      tick();
      g++;
    end
    check(tag, bus.gpu_idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_in    = '0;
    bus.cmd_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_idle",    bus.gpu_idle, 1);
    check("rst_accept",  bus.cmd_accept, 1);
    check("rst_gpu_cmd", bus.gpu_cmd, 0);
    check("rst_level",   bus.fifo_level, 0);
    check("rst_sub",     bus.gpu_cmd_submitted, 0);
    check("rst_reject",  bus.cmd_reject, 0);
    man_ready = 1'b0;
    #1 check("idle_follows_ready_lo", bus.gpu_idle, 0);
    man_ready = 1'b1;
    #1 check("idle_follows_ready_hi", bus.gpu_idle, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // CLS: submit one cycle after the push edge, single-cycle pulse.
    base = sub_q.size();
    bus.cmd_in = 16'h00E0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("cls_level1", bus.fifo_level, 1);
    check("cls_no_sub_yet", bus.gpu_cmd_submitted, 0);
    tick();
    check("cls_sub", bus.gpu_cmd_submitted, 1);
    check("cls_cmd", bus.gpu_cmd, 16'h00E0);
    check("cls_level0", bus.fifo_level, 0);
    tick();
    check("cls_pulse_single", bus.gpu_cmd_submitted, 0);
    check("cls_cmd_hold", bus.gpu_cmd, 16'h00E0);
    man_ready = 1'b0;
    tick();
    man_ready = 1'b1;
    tick();
    check("cls_back_idle", bus.gpu_idle, 1);
    check("cls_count", sub_q.size() - base, 1);

    // Illegal opcodes are dropped with a one-cycle reject pulse.
    bus.cmd_in = 16'h6A05;
    bus.cmd_valid = 1'b1;
    check("rej_accept", bus.cmd_accept, 1);
    tick();
    bus.cmd_valid = 1'b0;
    check("rej_pulse", bus.cmd_reject, 1);
    check("rej_level", bus.fifo_level, 0);
    tick();
    check("rej_pulse_end", bus.cmd_reject, 0);
    bus.cmd_in = 16'h00EE;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("rej_ret", bus.cmd_reject, 1);
    tick();
    tick();
    check("rej_no_sub", sub_q.size() - base, 1);
    check("rej_cmd_hold", bus.gpu_cmd, 16'h00E0);
    wait_idle("rej_idle");

    // Fill with GPU busy, fifth stalls, then a slow GPU drains in order.
    man_ready = 1'b0;
    base = sub_q.size();
    for (int i = 0; i < 4; i++) begin
      bus.cmd_in = vec3[i];
      bus.cmd_valid = 1'b1;
      check($sformatf("fill_accept%0d", i), bus.cmd_accept, 1);
      tick();
    end
    bus.cmd_in = vec3[4];
    check("full_accept", bus.cmd_accept, 0);
    check("full_level", bus.fifo_level, 4);
    tick();
    tick();
    check("stall_level", bus.fifo_level, 4);
    check("stall_no_sub", bus.gpu_cmd_submitted, 0);
    lag_len = 0;
    busy_len = 10;
    model_en = 1'b1;
    tick();
    check("pop_full_level", bus.fifo_level, 3);
    check("pop_full_accept", bus.cmd_accept, 1);
    check("pop_full_sub", bus.gpu_cmd_submitted, 1);
    check("pop_full_cmd", bus.gpu_cmd, 16'hD125);
    tick();
    check("fifth_level", bus.fifo_level, 4);
    bus.cmd_valid = 1'b0;
    wait_subs(base + 5, "drain5_done");
    for (int i = 0; i < 5; i++)
      check($sformatf("drain5_order%0d", i), sub_q[base + i], vec3[i]);
    check("slow_spacing", sub_cyc[base + 1] - sub_cyc[base], 13);
    repeat (20) tick();
    check("drain5_exact", sub_q.size() - base, 5);
    wait_idle("drain5_idle");

    // GPU lags 3 cycles before dropping ready: FSM waits, no duplicate submit.
    lag_len = 3;
    busy_len = 2;
    base = sub_q.size();
    bus.cmd_in = 16'hD7AB;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("lag_sub", bus.gpu_cmd_submitted, 1);
    check("lag_cmd", bus.gpu_cmd, 16'hD7AB);
    tick();
    tick();
    tick();
    check("lag_ready_hi", bus.gpu_ready, 1);
    check("lag_not_idle", bus.gpu_idle, 0);
    check("lag_no_dup", bus.gpu_cmd_submitted, 0);
    tick();
    check("lag_ready_lo", bus.gpu_ready, 0);
    tick();
    tick();
    tick();
    check("lag_idle", bus.gpu_idle, 1);
    check("lag_count", sub_q.size() - base, 1);

    // Instant GPU: back-to-back submits are 4 cycles apart.
    lag_len = 0;
    busy_len = 1;
    base = sub_q.size();
    bus.cmd_in = 16'hD111;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_in = 16'hD222;
    tick();
    bus.cmd_valid = 1'b0;
    wait_subs(base + 2, "inst_done");
    check("inst_order0", sub_q[base], 16'hD111);
    check("inst_order1", sub_q[base + 1], 16'hD222);
    check("inst_spacing", sub_cyc[base + 1] - sub_cyc[base], 4);
    wait_idle("inst_idle");

    // Simultaneous push and pop at level 2.
    model_en = 1'b0;
    man_ready = 1'b0;
    base = sub_q.size();
    bus.cmd_in = 16'hD0A1;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_in = 16'hD0B2;
    tick();
    check("pp_level2", bus.fifo_level, 2);
    bus.cmd_in = 16'hD0C3;
    man_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("pp_level_same", bus.fifo_level, 2);
    check("pp_sub", bus.gpu_cmd_submitted, 1);
    check("pp_cmd", bus.gpu_cmd, 16'hD0A1);
    model_en = 1'b1;
    wait_subs(base + 3, "pp_done");
    check("pp_order0", sub_q[base], 16'hD0A1);
    check("pp_order1", sub_q[base + 1], 16'hD0B2);
    check("pp_order2", sub_q[base + 2], 16'hD0C3);
    check("pp_level_end", bus.fifo_level, 0);
    wait_idle("pp_idle");

    // Reset during SUBMIT with 3 entries queued.
    model_en = 1'b0;
    man_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_in = 16'hD801 + 16'(i);
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("rs_level4", bus.fifo_level, 4);
    man_ready = 1'b1;
    tick();
    check("rs_sub", bus.gpu_cmd_submitted, 1);
    check("rs_level3", bus.fifo_level, 3);
    #1 rst = 1'b1;
    #1;
    check("rs_sub_clr", bus.gpu_cmd_submitted, 0);
    check("rs_level0", bus.fifo_level, 0);
    check("rs_gpu_cmd", bus.gpu_cmd, 0);
    check("rs_accept", bus.cmd_accept, 1);
    check("rs_idle", bus.gpu_idle, 1);
    tick();
    rst = 1'b0;
    base = sub_q.size();
    lag_len = 0;
    busy_len = 1;
    model_en = 1'b1;
    bus.cmd_in = 16'hD999;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("rs_new_sub", bus.gpu_cmd_submitted, 1);
    check("rs_new_cmd", bus.gpu_cmd, 16'hD999);
    repeat (15) tick();
    check("rs_count", sub_q.size() - base, 1);
    check("rs_final_idle", bus.gpu_idle, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
